// File: rtl/gf180mcu_sram_wrapper.sv
// gf180mcu_sram_wrapper
//   Single-port synchronous SRAM wrapper with GF180MCU macro-style controls:
//   active-low chip enable (cen), active-low global write enable (gwen) and
//   active-low per-bit write mask (wen).
//   Storage is a behavioural WORDS x WIDTH array with a registered read port.
//
//   Optional build macro: GF180MCU_SRAM_INIT_ZERO_EN
//     defined   -> every array word starts at 0
//     undefined -> array starts unknown (X), like the silicon macro
//   Read, write and reset behaviour is the same in both builds.
//
//   Protocol: no handshake. Every edge with cen=0 and rst=0 performs one
//   access, so accesses can be issued back-to-back on every cycle. A read
//   issued at edge N shows up on dout right after edge N. dout then holds
//   until the next read edge or reset edge.
module gf180mcu_sram_wrapper #(
  parameter int WORDS = 64,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         gwen,
  input  logic [WIDTH-1:0]             wen,
  input  logic [$clog2(WORDS)-1:0]     addr,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout
);

  localparam int ADDR_WIDTH = $clog2(WORDS);

  // Word count widened by one bit, so the range check also works when
  // WORDS is an exact power of two.
  localparam logic [ADDR_WIDTH:0] WORDS_L = WORDS[ADDR_WIDTH:0];

`ifdef GF180MCU_SRAM_INIT_ZERO_EN
  logic [WIDTH-1:0] mem [WORDS] = '{default: '0};
`else
  logic [WIDTH-1:0] mem [WORDS];
`endif

  logic in_range;
  logic do_read;
  logic do_write;

  // Decode the access. Reset suppresses any access in the same cycle.
  always_comb begin
    in_range = ({1'b0, addr} < WORDS_L);
    do_read  = !rst && !cen && gwen;
    do_write = !rst && !cen && !gwen && in_range;
  end

  // Bit-masked write: only bits with wen[i]=0 take din[i].
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[addr] <= (mem[addr] & wen) | (din & ~wen);
    end
  end

  // Registered read port. Reset clears dout, and out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (do_read) begin
      dout <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_gf180mcu_sram_wrapper.sv
// tb_gf180mcu_sram_wrapper
//   Table-driven checks for the SRAM wrapper. Read results come from a
//   scoreboard queue, and non-read cycles check that dout holds its value.
module tb_gf180mcu_sram_wrapper;

  localparam int WORDS = 64;
  localparam int WIDTH = 32;
  localparam int AW    = 6;

  typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;

  typedef struct {
    op_e             op;
    logic [AW-1:0]   addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] wen;
    logic [WIDTH-1:0] exp;
    string           name;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             cen;
  logic             gwen;
  logic [WIDTH-1:0] wen;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_exp;
  int               checks;
  int               failures;
  vec_t             vecs[$];
  logic [WIDTH-1:0] model [16];

  gf180mcu_sram_wrapper #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .gwen (gwen),
    .wen  (wen),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(op_e op, logic [AW-1:0] a, logic [WIDTH-1:0] d,
                              logic [WIDTH-1:0] w, logic [WIDTH-1:0] e, string n);
    vec_t v;
    v.op = op; v.addr = a; v.din = d; v.wen = w; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: dout=%h expected=%h", name, act, expv);
    end
  endtask

  // Driver: apply one cycle, then check dout after the edge
  task automatic do_cycle(input op_e op, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] w,
                          input logic [WIDTH-1:0] e, input logic r, input string name);
    logic [WIDTH-1:0] got;
    @(negedge clk);
    rst  = r;
    cen  = (op == OP_IDLE);
    gwen = (op != OP_WRITE);
    addr = a;
    din  = d;
    wen  = w;
    if (op == OP_READ && !r) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      last_exp = '0;
      check({name, "_reset"}, dout, '0);
    end else if (op == OP_READ) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty, dout=%h", name, dout);
      end else begin
        got = exp_q.pop_front();
        last_exp = got;
        check(name, dout, got);
      end
    end else begin
      check({name, "_hold"}, dout, last_exp);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] nv;
    int               k;

    checks = 0; failures = 0; last_exp = '0;
    rst = 1'b0; cen = 1'b1; gwen = 1'b1; wen = '1; addr = '0; din = '0;

    // Idle for 20 cycles, then a single reset cycle
    repeat (20) @(posedge clk);
    do_cycle(OP_IDLE, 6'h00, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, "init");
    do_cycle(OP_IDLE, 6'h00, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, "post_reset_idle");

    // Directed vector table
    vecs.push_back(mk(OP_WRITE, 6'h0A, 32'hFFFFFFFF, 32'h00000000, 32'h0, "wr_0a"));
    vecs.push_back(mk(OP_READ,  6'h0A, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, "rd_0a"));
    vecs.push_back(mk(OP_WRITE, 6'h0B, 32'h00000000, 32'h00000000, 32'h0, "wr_0b_clear"));
    vecs.push_back(mk(OP_WRITE, 6'h0B, 32'hFACECAFE, 32'hFFFFFFFF, 32'h0, "wr_0b_masked"));
    vecs.push_back(mk(OP_READ,  6'h0B, 32'h0,        32'hFFFFFFFF, 32'h00000000, "rd_0b"));
    vecs.push_back(mk(OP_WRITE, 6'h0C, 32'h00000000, 32'h00000000, 32'h0, "wr_0c_clear"));
    vecs.push_back(mk(OP_WRITE, 6'h0C, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, "wr_0c_masked"));
    vecs.push_back(mk(OP_READ,  6'h0C, 32'h0,        32'hFFFFFFFF, 32'h00000000, "rd_0c"));
    vecs.push_back(mk(OP_WRITE, 6'h0D, 32'h99999999, 32'h00000000, 32'h0, "wr_0d_full"));
    vecs.push_back(mk(OP_WRITE, 6'h0D, 32'h12345678, 32'hFFFF0000, 32'h0, "wr_0d_part"));
    vecs.push_back(mk(OP_READ,  6'h0D, 32'h0,        32'hFFFFFFFF, 32'h99995678, "rd_0d"));
    vecs.push_back(mk(OP_WRITE, 6'h3F, 32'h99999999, 32'h00000000, 32'h0, "wr_3f"));
    vecs.push_back(mk(OP_READ,  6'h3F, 32'h0,        32'hFFFFFFFF, 32'h99999999, "rd_3f"));
    vecs.push_back(mk(OP_READ,  6'h0A, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_0a_1"));
    vecs.push_back(mk(OP_READ,  6'h3F, 32'h0,        32'hFFFFFFFF, 32'h99999999, "b2b_3f"));
    vecs.push_back(mk(OP_READ,  6'h0A, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_0a_2"));
    vecs.push_back(mk(OP_WRITE, 6'h05, 32'h11223344, 32'h00000000, 32'h0, "wr_05"));
    vecs.push_back(mk(OP_IDLE,  6'h05, 32'h0,        32'hFFFFFFFF, 32'h0, "idle_1"));
    vecs.push_back(mk(OP_IDLE,  6'h05, 32'h0,        32'hFFFFFFFF, 32'h0, "idle_2"));
    vecs.push_back(mk(OP_IDLE,  6'h05, 32'h0,        32'hFFFFFFFF, 32'h0, "idle_3"));
    vecs.push_back(mk(OP_READ,  6'h05, 32'h0,        32'hFFFFFFFF, 32'h11223344, "rd_05"));

    foreach (vecs[i])
      do_cycle(vecs[i].op, vecs[i].addr, vecs[i].din, vecs[i].wen, vecs[i].exp,
               1'b0, vecs[i].name);

    // Reset coincident with a write: the write is suppressed and dout clears
    do_cycle(OP_WRITE, 6'h05, 32'hDEADBEEF, 32'h00000000, 32'h0, 1'b1, "rst_wr_05");
    do_cycle(OP_IDLE,  6'h05, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, "after_rst");
    do_cycle(OP_READ,  6'h05, 32'h0, 32'hFFFFFFFF, 32'h11223344, 1'b0, "rd_05_kept");

    // Reset coincident with a read: dout clears, then the first access is normal
    do_cycle(OP_READ,  6'h0A, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, "rst_rd_0a");
    do_cycle(OP_READ,  6'h0A, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "rd_0a_first");

    // Random masked writes over a 16-word window, checked against a bench model
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model[i] = d;
      do_cycle(OP_WRITE, 6'(32 + i), d, 32'h0, 32'h0, 1'b0, "rnd_init");
    end
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 15);
      d = $urandom;
      w = $urandom;
      nv = model[k];
      for (int b = 0; b < WIDTH; b++)
        if (w[b] == 1'b0) nv[b] = d[b];
      model[k] = nv;
      do_cycle(OP_WRITE, 6'(32 + k), d, w, 32'h0, 1'b0, "rnd_wr");
      do_cycle(OP_READ,  6'(32 + k), 32'h0, 32'hFFFFFFFF, model[k], 1'b0, "rnd_rd");
    end

    // Final report
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
